// File: rtl/sim_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sim_ctrl_pkg                                                    |
// | Purpose  : Shared constants for the simulation/system controller: OCP      |
// |            command/response codes, FSM state encodings, register window    |
// |            word indices and STATUS bit positions, plus a STATUS helper.    |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package sim_ctrl_pkg;

  // OCP command and response codes
  localparam logic [2:0] c_ocp_cmd_idle  = 3'b000;
  localparam logic [2:0] c_ocp_cmd_wr    = 3'b001;
  localparam logic [2:0] c_ocp_cmd_rd    = 3'b010;
  localparam logic [1:0] c_ocp_resp_null = 2'b00;
  localparam logic [1:0] c_ocp_resp_dva  = 2'b01;

  // Controller FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t c_st_reset = 2'd0;
  localparam state_t c_st_run   = 2'd1;
  localparam state_t c_st_done  = 2'd2;

  // Register window, indexed by MAddr[4:2]
  localparam logic [2:0] c_reg_status  = 3'd0;
  localparam logic [2:0] c_reg_exit    = 3'd1;
  localparam logic [2:0] c_reg_cycles  = 3'd2;
  localparam logic [2:0] c_reg_wdog    = 3'd3;
  localparam logic [2:0] c_reg_console = 3'd4;

  // STATUS register bit positions
  localparam int c_status_done_bit    = 0;
  localparam int c_status_pass_bit    = 1;
  localparam int c_status_timeout_bit = 2;

  function automatic logic [31:0] status_word(input logic done,
                                              input logic pass,
                                              input logic timeout);
    logic [31:0] w;
    w                       = '0;
    w[c_status_done_bit]    = done;
    w[c_status_pass_bit]    = pass;
    w[c_status_timeout_bit] = timeout;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sim_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sim_ctrl                                                        |
// | Purpose  : Simulation/system controller. Stretches the external reset into |
// |            o_sys_nrst, runs a watchdog and a saturating cycle counter, and |
// |            exposes an OCP slave register window for pass/fail reporting    |
// |            and console output.                                             |
// | Ports    : clk, nrst (sync, active-low)  - clock and reset                 |
// |            o_sys_nrst                    - stretched system reset          |
// |            i_MAddr/i_MCmd/i_MData/i_MByteEn, o_SCmdAccept/o_SData/o_SResp |
// |                                          - OCP slave, no wait states       |
// |            o_con_valid/o_con_data        - console byte strobe             |
// |            o_done/o_pass/o_timeout/o_exit_code - run result                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sim_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 10,
  parameter int unsigned WDOG_CYCLES = 4096,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        o_sys_nrst,
  input  logic [31:0] i_MAddr,
  input  logic [2:0]  i_MCmd,
  input  logic [31:0] i_MData,
  input  logic [3:0]  i_MByteEn,
  output logic        o_SCmdAccept,
  output logic [31:0] o_SData,
  output logic [1:0]  o_SResp,
  output logic        o_con_valid,
  output logic [7:0]  o_con_data,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_timeout,
  output logic [31:0] o_exit_code
);

  localparam logic [CNT_WIDTH-1:0] c_wdog_load = CNT_WIDTH'(WDOG_CYCLES);
  localparam logic [CNT_WIDTH-1:0] c_wdog_one  = CNT_WIDTH'(1);
  localparam logic [31:0]          c_rst_last  = 32'(RST_CYCLES - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [31:0]          r_rst_cnt;
  logic [CNT_WIDTH-1:0] r_cycles;
  logic [CNT_WIDTH-1:0] r_wdog;
  logic                 r_sys_nrst;
  logic                 r_pass;
  logic                 r_timeout;
  logic [31:0]          r_exit_code;
  logic                 r_con_valid;
  logic [7:0]           r_con_data;
  logic [1:0]           r_sresp;
  logic [31:0]          r_sdata;

  // Command decode
  logic        w_accept;
  logic        w_wr;
  logic        w_rd;
  logic [2:0]  w_idx;
  logic        w_run;
  logic        w_exit_wr;
  logic        w_kick;
  logic        w_con_wr;
  logic        w_expire;
  logic [31:0] w_rdata;
  logic        w_unused_bits;

  assign w_accept  = (i_MCmd != c_ocp_cmd_idle);
  assign w_wr      = (i_MCmd == c_ocp_cmd_wr);
  assign w_rd      = (i_MCmd == c_ocp_cmd_rd);
  assign w_idx     = i_MAddr[4:2];
  assign w_run     = (r_state == c_st_run);

  // Side-effecting writes only act while running; in RESET/DONE they are
  // acknowledged but dropped, which also makes the first EXIT the only one.
  assign w_exit_wr = w_run && w_wr && (w_idx == c_reg_exit);
  assign w_kick    = w_run && w_wr && (w_idx == c_reg_wdog);
  assign w_con_wr  = w_run && w_wr && (w_idx == c_reg_console) && i_MByteEn[0];

  // Expiry is the edge on which the watchdog steps from 1 to 0; a reload on
  // that same edge cancels it.
  assign w_expire  = w_run && !w_kick && (r_wdog <= c_wdog_one);

  // Upper address bits are decoded by the interconnect, and only byte lane 0
  // matters (for CONSOLE).
  assign w_unused_bits = ^{i_MAddr[31:5], i_MAddr[1:0], i_MByteEn[3:1]};

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      c_reg_status: w_rdata = status_word(r_state == c_st_done, r_pass, r_timeout);
      c_reg_exit:   w_rdata = r_exit_code;
      c_reg_cycles: w_rdata = 32'(r_cycles);
      c_reg_wdog:   w_rdata = 32'(r_wdog);
      default:      w_rdata = '0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= c_st_reset;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next-state logic. EXIT and expiry both lead to DONE; which flag gets
  // set is resolved in the datapath below.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_reset: if (r_rst_cnt == c_rst_last) w_next_state = c_st_run;
      c_st_run:   if (w_exit_wr || w_expire)   w_next_state = c_st_done;
      c_st_done:  w_next_state = c_st_done;
      default:    w_next_state = c_st_reset;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_rst_cnt   <= '0;
      r_cycles    <= '0;
      r_wdog      <= '0;
      r_sys_nrst  <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_exit_code <= '0;
      r_con_valid <= 1'b0;
      r_con_data  <= '0;
      r_sresp     <= c_ocp_resp_null;
      r_sdata     <= '0;
    end else begin
      r_sresp     <= w_accept ? c_ocp_resp_dva : c_ocp_resp_null;
      r_sdata     <= w_rd ? w_rdata : '0;
      r_con_valid <= w_con_wr;
      if (w_con_wr) begin
        r_con_data <= i_MData[7:0];
      end

      // Released one cycle after RUN entry, dropped on the same edge as DONE.
      r_sys_nrst <= w_run && (w_next_state == c_st_run);

      case (r_state)
        c_st_reset: begin
          r_rst_cnt <= r_rst_cnt + 32'd1;
          if (w_next_state == c_st_run) begin
            r_wdog <= c_wdog_load;
          end
        end
        c_st_run: begin
          if (r_cycles != '1) begin
            r_cycles <= r_cycles + c_wdog_one;
          end
          if (w_kick) begin
            r_wdog <= c_wdog_load;
          end else if (r_wdog != '0) begin
            r_wdog <= r_wdog - c_wdog_one;
          end
          if (w_exit_wr) begin
            r_exit_code <= i_MData;
            r_pass      <= (i_MData == 32'd0);
          end else if (w_expire) begin
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    o_done       = (r_state == c_st_done);
    o_sys_nrst   = r_sys_nrst;
    o_SCmdAccept = w_accept;
    o_SResp      = r_sresp;
    o_SData      = r_sdata;
    o_con_valid  = r_con_valid;
    o_con_data   = r_con_data;
    o_pass       = r_pass;
    o_timeout    = r_timeout;
    o_exit_code  = r_exit_code;
  end

endmodule
`default_nettype wire

// File: tb/tb_sim_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sim_ctrl                                                     |
// | Purpose  : Self-checking bench for sim_ctrl: directed vector table, hand   |
// |            sequences for watchdog/EXIT corner cases and counter            |
// |            saturation, and a randomized run against a reference model.     |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sim_ctrl;

  localparam int unsigned RST  = 10;
  localparam int unsigned WDOG = 16;

  localparam logic [2:0] IDL = 3'd0;
  localparam logic [2:0] WR  = 3'd1;
  localparam logic [2:0] RD  = 3'd2;
  localparam logic [1:0] NUL = 2'd0;
  localparam logic [1:0] DVA = 2'd1;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        nrst2 = 1'b0;
  logic [31:0] maddr = '0;
  logic [2:0]  mcmd = '0;
  logic [31:0] mdata = '0;
  logic [3:0]  mbe = '0;

  logic        sys_nrst, scmd_accept, con_valid, done, pass, timeout;
  logic [31:0] sdata, exit_code;
  logic [1:0]  sresp;
  logic [7:0]  con_data;

  logic        d2_done, d2_unused_sys, d2_unused_acc, d2_unused_cv, d2_unused_pass, d2_timeout;
  logic [31:0] d2_sdata, d2_unused_exit;
  logic [1:0]  d2_sresp;
  logic [7:0]  d2_unused_cd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sim_ctrl #(.RST_CYCLES(RST), .WDOG_CYCLES(WDOG), .CNT_WIDTH(32)) dut (
    .clk(clk), .nrst(nrst), .o_sys_nrst(sys_nrst),
    .i_MAddr(maddr), .i_MCmd(mcmd), .i_MData(mdata), .i_MByteEn(mbe),
    .o_SCmdAccept(scmd_accept), .o_SData(sdata), .o_SResp(sresp),
    .o_con_valid(con_valid), .o_con_data(con_data),
    .o_done(done), .o_pass(pass), .o_timeout(timeout), .o_exit_code(exit_code)
  );

  // Narrow counters to exercise saturation of the cycle counter
  sim_ctrl #(.RST_CYCLES(1), .WDOG_CYCLES(12), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .nrst(nrst2), .o_sys_nrst(d2_unused_sys),
    .i_MAddr(maddr), .i_MCmd(mcmd), .i_MData(mdata), .i_MByteEn(mbe),
    .o_SCmdAccept(d2_unused_acc), .o_SData(d2_sdata), .o_SResp(d2_sresp),
    .o_con_valid(d2_unused_cv), .o_con_data(d2_unused_cd),
    .o_done(d2_done), .o_pass(d2_unused_pass), .o_timeout(d2_timeout), .o_exit_code(d2_unused_exit)
  );

  // ---------------- reference model (spec-level) ----------------
  bit          m_in_reset = 1'b1;
  bit          m_done, m_pass, m_timeout, m_sys_nrst, m_con_valid;
  int unsigned m_rst_seen;
  logic [31:0] m_cycles, m_wdog, m_exit, m_sdata;
  logic [1:0]  m_resp;
  logic [7:0]  m_con_data;

  function automatic void model_step(input logic n, input logic [2:0] c, input logic [31:0] a,
                                     input logic [31:0] d, input logic [3:0] b);
    bit          running;
    logic [2:0]  idx;
    logic [31:0] rv;
    if (!n) begin
      m_in_reset = 1; m_rst_seen = 0; m_done = 0; m_pass = 0; m_timeout = 0;
      m_sys_nrst = 0; m_con_valid = 0; m_con_data = 0; m_cycles = 0; m_wdog = 0;
      m_exit = 0; m_sdata = 0; m_resp = NUL;
      return;
    end
    running = !m_in_reset && !m_done;
    idx = a[4:2];
    case (idx)
      3'd0:    rv = {29'd0, m_timeout, m_pass, m_done};
      3'd1:    rv = m_exit;
      3'd2:    rv = m_cycles;
      3'd3:    rv = m_wdog;
      default: rv = 0;
    endcase
    m_resp  = (c != IDL) ? DVA : NUL;
    m_sdata = (c == RD) ? rv : 32'd0;
    m_con_valid = running && c == WR && idx == 3'd4 && b[0];
    if (m_con_valid) m_con_data = d[7:0];
    if (m_in_reset) begin
      m_rst_seen++;
      if (m_rst_seen == RST) begin
        m_in_reset = 0;
        m_wdog = WDOG;
      end
    end else if (running) begin
      if (m_cycles != 32'hFFFF_FFFF) m_cycles++;
      if (c == WR && idx == 3'd3) m_wdog = WDOG;
      else m_wdog--;
      if (c == WR && idx == 3'd1) begin
        m_exit = d; m_pass = (d == 0); m_done = 1;
      end else if (m_wdog == 0) begin
        m_done = 1; m_timeout = 1; m_pass = 0;
      end
    end
    // the system runs only across edges that start and end in RUN
    m_sys_nrst = running && !m_done;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic s, input logic [1:0] r,
                            input logic [31:0] sd, input logic cv, input logic [7:0] cd,
                            input logic dn, input logic ps, input logic to, input logic [31:0] ex);
    chk({tag, "_sys_nrst"}, {31'd0, sys_nrst}, {31'd0, s});
    chk({tag, "_sresp"}, {30'd0, sresp}, {30'd0, r});
    chk({tag, "_sdata"}, sdata, sd);
    chk({tag, "_con_valid"}, {31'd0, con_valid}, {31'd0, cv});
    if (cv) chk({tag, "_con_data"}, {24'd0, con_data}, {24'd0, cd});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, dn});
    chk({tag, "_pass"}, {31'd0, pass}, {31'd0, ps});
    chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, to});
    chk({tag, "_exit_code"}, exit_code, ex);
  endtask

  // One clock: drive at negedge, check accept, sample #1 after posedge.
  task automatic apply(input logic n, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    nrst = n; mcmd = c; maddr = a; mdata = d; mbe = b;
    #1;
    chk("accept", {31'd0, scmd_accept}, {31'd0, (c != IDL)});
    @(posedge clk);
    model_step(n, c, a, d, b);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(1'b1, IDL, 32'd0, 32'd0, 4'd0);
  endtask

  // Reset, then release; returns on the edge that enters RUN.
  task automatic reset_and_run();
    apply(1'b0, IDL, 32'd0, 32'd0, 4'd0);
    apply(1'b0, IDL, 32'd0, 32'd0, 4'd0);
    idle(RST);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        nrst;
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        sys_nrst;
    logic [1:0]  resp;
    logic [31:0] sdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] exit_code;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic n, input logic [2:0] c, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] b,
                              input logic s, input logic [1:0] r, input logic [31:0] sd,
                              input logic cv, input logic [7:0] cd,
                              input logic dn, input logic ps, input logic to, input logic [31:0] ex);
    vec_t v;
    v.nrst = n; v.cmd = c; v.addr = a; v.data = d; v.be = b;
    v.sys_nrst = s; v.resp = r; v.sdata = sd; v.con_valid = cv; v.con_data = cd;
    v.done = dn; v.pass = ps; v.timeout = to; v.exit_code = ex;
    tbl.push_back(v);
  endfunction

  initial begin
    // nrst low 3 cycles, all outputs 0
    for (int i = 0; i < 3; i++) add(0, IDL, 0, 0, 0,  0, NUL, 0, 0, 0,  0, 0, 0, 0);
    // 10 cycles of stretch after release, then o_sys_nrst rises on the 11th
    for (int i = 0; i < 10; i++) add(1, IDL, 0, 0, 0, 0, NUL, 0, 0, 0, 0, 0, 0, 0);
    add(1, IDL, 0, 0, 0,                     1, NUL, 0, 0, 8'h00,  0, 0, 0, 0);
    add(1, WR,  32'h10, 32'h41, 4'b0001,     1, DVA, 0, 1, 8'h41,  0, 0, 0, 0);
    add(1, WR,  32'h10, 32'h42, 4'b0010,     1, DVA, 0, 0, 8'h00,  0, 0, 0, 0);
    add(1, IDL, 0, 0, 0,                     1, NUL, 0, 0, 8'h00,  0, 0, 0, 0);
    add(1, RD,  32'h00, 0, 0,                1, DVA, 0, 0, 8'h00,  0, 0, 0, 0);
    add(1, WR,  32'h04, 32'd0, 4'hF,         0, DVA, 0, 0, 8'h00,  1, 1, 0, 0);
    add(1, WR,  32'h04, 32'd7, 4'hF,         0, DVA, 0, 0, 8'h00,  1, 1, 0, 0);
    add(1, RD,  32'h00, 0, 0,                0, DVA, 3, 0, 8'h00,  1, 1, 0, 0);
    add(1, WR,  32'h10, 32'h55, 4'b0001,     0, DVA, 0, 0, 8'h00,  1, 1, 0, 0);
    add(1, RD,  32'h04, 0, 0,                0, DVA, 0, 0, 8'h00,  1, 1, 0, 0);
    // nrst low in DONE clears everything
    add(0, IDL, 0, 0, 0,                     0, NUL, 0, 0, 8'h00,  0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(1, IDL, 0, 0, 0, 0, NUL, 0, 0, 0, 0, 0, 0, 0);
    // fresh run: failing exit code, then a second EXIT that must be ignored
    add(1, WR,  32'h04, 32'd7, 4'hF,         0, DVA, 0, 0, 8'h00,  1, 0, 0, 7);
    add(1, RD,  32'h04, 0, 0,                0, DVA, 7, 0, 8'h00,  1, 0, 0, 7);
    add(1, RD,  32'h1C, 0, 0,                0, DVA, 0, 0, 8'h00,  1, 0, 0, 7);
    add(1, WR,  32'h04, 32'd0, 4'hF,         0, DVA, 0, 0, 8'h00,  1, 0, 0, 7);

    foreach (tbl[i]) begin
      apply(tbl[i].nrst, tbl[i].cmd, tbl[i].addr, tbl[i].data, tbl[i].be);
      check_outs($sformatf("tbl%0d", i), tbl[i].sys_nrst, tbl[i].resp, tbl[i].sdata,
                 tbl[i].con_valid, tbl[i].con_data, tbl[i].done, tbl[i].pass,
                 tbl[i].timeout, tbl[i].exit_code);
    end

    // CYCLES read after 20 RUN cycles (one kick keeps the watchdog alive)
    reset_and_run();
    idle(9);
    apply(1'b1, WR, 32'h0C, 32'd0, 4'hF);
    idle(10);
    apply(1'b1, RD, 32'h08, 32'd0, 4'd0);
    chk("cycles_resp", {30'd0, sresp}, {30'd0, DVA});
    chk("cycles_val", sdata, 32'd20);
    idle(1);
    chk("cycles_resp_1cyc", {30'd0, sresp}, {30'd0, NUL});
    chk("cycles_sdata_clr", sdata, 32'd0);

    // Watchdog expiry after exactly WDOG RUN cycles
    reset_and_run();
    idle(WDOG - 1);
    chk("wdog_not_yet", {31'd0, done}, 32'd0);
    idle(1);
    chk("wdog_done", {31'd0, done}, 32'd1);
    chk("wdog_timeout", {31'd0, timeout}, 32'd1);
    chk("wdog_pass", {31'd0, pass}, 32'd0);
    chk("wdog_sys_nrst", {31'd0, sys_nrst}, 32'd0);
    apply(1'b1, RD, 32'h00, 32'd0, 4'd0);
    chk("wdog_status", sdata, 32'd5);
    apply(1'b0, IDL, 32'd0, 32'd0, 4'd0);
    chk("rst_done_clr", {31'd0, done}, 32'd0);
    chk("rst_timeout_clr", {31'd0, timeout}, 32'd0);

    // EXIT on the expiry cycle wins
    reset_and_run();
    idle(WDOG - 1);
    apply(1'b1, WR, 32'h04, 32'd5, 4'hF);
    chk("exitexp_done", {31'd0, done}, 32'd1);
    chk("exitexp_timeout", {31'd0, timeout}, 32'd0);
    chk("exitexp_code", exit_code, 32'd5);

    // Kick on the expiry cycle wins
    reset_and_run();
    idle(WDOG - 1);
    apply(1'b1, WR, 32'h0C, 32'd0, 4'hF);
    chk("kickexp_done", {31'd0, done}, 32'd0);
    apply(1'b1, RD, 32'h0C, 32'd0, 4'd0);
    chk("kickexp_wdog", sdata, WDOG);

    // Periodic kicks keep the run alive
    reset_and_run();
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 9) apply(1'b1, WR, 32'h0C, 32'd0, 4'hF);
      else apply(1'b1, IDL, 32'd0, 32'd0, 4'd0);
    end
    chk("kick_alive_done", {31'd0, done}, 32'd0);
    chk("kick_alive_sys", {31'd0, sys_nrst}, 32'd1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 2000; i++) begin
      logic        n;
      logic [2:0]  c;
      logic [2:0]  idx;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
      int          r;
      n = ($urandom_range(0, 199) != 0);
      if (m_done && $urandom_range(0, 15) == 0) n = 1'b0;
      r = $urandom_range(0, 9);
      c = (r < 5) ? IDL : (r < 8) ? WR : (r == 8) ? RD : 3'($urandom_range(3, 7));
      idx = 3'($urandom_range(0, 7));
      if (c == WR && idx == 3'd1 && $urandom_range(0, 3) != 0) idx = 3'd3;
      if (c == WR && $urandom_range(0, 2) == 0) idx = 3'd3;
      a = $urandom;
      a[4:2] = idx;
      d = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      b = 4'($urandom_range(0, 15));
      apply(n, c, a, d, b);
      check_outs($sformatf("rnd%0d", i), m_sys_nrst, m_resp, m_sdata, m_con_valid,
                 m_con_data, m_done, m_pass, m_timeout, m_exit);
    end

    // Cycle counter saturation on the 4-bit instance
    apply(1'b0, IDL, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    nrst2 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i % 8 == 7) apply(1'b0, WR, 32'h0C, 32'd0, 4'hF);
      else apply(1'b0, IDL, 32'd0, 32'd0, 4'd0);
    end
    apply(1'b0, RD, 32'h08, 32'd0, 4'd0);
    chk("sat_resp", {30'd0, d2_sresp}, {30'd0, DVA});
    chk("sat_cycles", d2_sdata, 32'd15);
    chk("sat_done", {31'd0, d2_done}, 32'd0);
    chk("sat_timeout", {31'd0, d2_timeout}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
